repeated_sub_divider: RTL
=========================

Name: repeated_sub_divider

Overview:
- Unsigned integer divider; computes quotient and remainder by repeated subtraction of the divisor from the dividend.
- Inverse companion of the repeated-add multiplier in the readout arithmetic path.
- Single-shot start/done handshake; latency depends on the data (quotient + 1 cycles).
- Divide-by-zero is flagged explicitly; the block never hangs.

Parameters:
- WIDTH_IN, 8, width of dividend, divisor, quotient and remainder.

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  request a division. Sampled only in IDLE.
- dividend  input  WIDTH_IN  unsigned dividend. Sampled with start.
- divisor  input  WIDTH_IN  unsigned divisor. Sampled with start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- quotient  output  WIDTH_IN  registered quotient. Held until the next done.
- remainder  output  WIDTH_IN  registered remainder. Held until the next done.
- div_by_zero  output  1  set with done when divisor was 0. Held until the next done.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE. busy, done, quotient, remainder and div_by_zero all go to 0. Internal rem_r, div_r and quot_r go to 0.
- Reset mid-operation: the division is abandoned and no done is produced.
- States: IDLE and SUB.
- IDLE, start=1, divisor!=0:
  - rem_r<=dividend, div_r<=divisor, quot_r<=0.
  - busy<=1, state<=SUB.
- IDLE, start=1, divisor==0:
  - quotient<=all ones, remainder<=dividend, div_by_zero<=1, done<=1.
  - Stay in IDLE; busy stays 0.
- IDLE, start=0: nothing changes.
- SUB, rem_r>=div_r: rem_r<=rem_r-div_r, quot_r<=quot_r+1.
- SUB, rem_r<div_r:
  - quotient<=quot_r, remainder<=rem_r, div_by_zero<=0, done<=1.
  - busy<=0, state<=IDLE.
- done is high for exactly one cycle after the edge that writes the results; it is cleared at every other edge.
- Latency: start is accepted at edge E0.
  - divisor!=0: done is high in the cycle after edge E(q+1), i.e. q+1 cycles, where q=floor(dividend/divisor).
  - divisor==0: done is high in the cycle after E0 (1 cycle).
- Worst case: dividend=2^WIDTH_IN-1, divisor=1, giving 2^WIDTH_IN cycles. quot_r never overflows WIDTH_IN bits.
- start while busy=1 is ignored; dividend and divisor are not re-sampled.
- start in the done cycle: the state is already IDLE, so the request is accepted. The outputs keep the previous results until the new done.
- Comparison and subtraction are unsigned and exactly WIDTH_IN bits wide. No sign handling.

Optional Feature:
- Macro: RSD_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycles, WIDTH_IN+1 bits, reset value 0.
  - An internal counter clears on start acceptance and increments on every SUB cycle.
  - cycles is registered with done. It equals the number of SUB cycles, i.e. q+1, or 0 on divide-by-zero.
  - cycles is held until the next done.
- Not defined: no port, no counter logic. All other behaviour is identical.

Test Plan:
- Basic: start, dividend=100, divisor=7 -> done 15 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0; busy high 15 cycles.
- Dividend below divisor: 5/9 -> done after 1 cycle; quotient=0, remainder=5. Equal operands: 9/9 -> quotient=1, remainder=0 after 2 cycles.
- Worst case (WIDTH_IN=8): 255/1 -> quotient=255, remainder=0, done after 256 cycles, no wrap. With RSD_CYCLE_COUNT_EN, cycles=256.
- Divide-by-zero: 42/0 -> done 1 cycle after start; quotient=255, remainder=42, div_by_zero=1; busy never high. A following 10/3 -> quotient=3, remainder=1, div_by_zero=0.
- Handshake: start pulsed again mid-division with 200/1 -> ignored; original 100/7 result returned. Start asserted in the done cycle -> accepted; previous outputs held until the new done.
- Reset: RST=1 for 1 cycle during SUB of 100/7 -> all outputs 0 next cycle, no done. Next start of 20/4 -> quotient=5, remainder=0.

Source files
------------

// File: rtl/repeated_sub_divider.sv
// ============================================================================
// repeated_sub_divider : unsigned divider by repeated subtraction (q+1 cycles)
// Optional macro RSD_CYCLE_COUNT_EN adds the 'cycles' output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module repeated_sub_divider #(
    parameter int WIDTH_IN = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [WIDTH_IN-1:0] dividend,
    input  logic [WIDTH_IN-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [WIDTH_IN-1:0] quotient,
    output logic [WIDTH_IN-1:0] remainder,
    output logic                div_by_zero
`ifdef RSD_CYCLE_COUNT_EN
    ,
    output logic [WIDTH_IN:0]   cycles
`endif
);

    localparam logic [WIDTH_IN-1:0] ALL_ONES = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SUB  = 1'b1
    } state_t;

    state_t              state_q;
    logic [WIDTH_IN-1:0] rem_q;
    logic [WIDTH_IN-1:0] div_q;
    logic [WIDTH_IN-1:0] quot_q;
    logic [WIDTH_IN-1:0] quotient_q;
    logic [WIDTH_IN-1:0] remainder_q;
    logic                busy_q;
    logic                done_q;
    logic                dbz_q;

    logic [WIDTH_IN-1:0] rem_d;
    logic [WIDTH_IN-1:0] quot_d;

    assign rem_d  = rem_q - div_q;
    assign quot_d = quot_q + 1'b1;

`ifdef RSD_CYCLE_COUNT_EN
    logic [WIDTH_IN:0] cnt_q;
    logic [WIDTH_IN:0] cycles_q;
    logic [WIDTH_IN:0] cnt_d;

    assign cnt_d  = cnt_q + 1'b1;
    assign cycles = cycles_q;
`endif

    // quot_q cannot overflow: it reaches at most dividend/1 = 2^WIDTH_IN-1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            div_q       <= '0;
            quot_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef RSD_CYCLE_COUNT_EN
            cnt_q       <= '0;
            cycles_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
`ifdef RSD_CYCLE_COUNT_EN
                        cnt_q <= '0;
`endif
                        if (divisor != '0) begin
                            rem_q   <= dividend;
                            div_q   <= divisor;
                            quot_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_SUB;
                        end else begin
                            quotient_q  <= ALL_ONES;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
`ifdef RSD_CYCLE_COUNT_EN
                            cycles_q    <= '0;
`endif
                        end
                    end
                end
                S_SUB: begin
`ifdef RSD_CYCLE_COUNT_EN
                    cnt_q <= cnt_d;
`endif
                    if (rem_q >= div_q) begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                    end else begin
                        quotient_q  <= quot_q;
                        remainder_q <= rem_q;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
`ifdef RSD_CYCLE_COUNT_EN
                        cycles_q    <= cnt_d;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
